instruction_fetch_unit: RTL and testbench

//  Fetch stage sitting directly upstream of instruction_memory: owns the PC,

---
 rtl/instruction_fetch_unit_if.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control from decode/execute, the instruction memory
// address/data pair, and the IF/ID pipeline register outputs.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 17
);
    logic              stall;
    logic              flush;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pc_plus4;
    logic              ifid_valid;
    logic              halted;
    logic              misalign_err;

    // Fetch unit side.
    modport master (
        input  stall, flush, branch_taken, branch_target, jump, jump_target,
        input  imem_data,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted,
        output misalign_err
    );

    // Surrounding pipeline and instruction memory side.
    modport slave (
        output stall, flush, branch_taken, branch_target, jump, jump_target,
        output imem_data,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted,
        input  misalign_err
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory combinationally and
// captures the returned word into the IF/ID register. Redirects (jump over
// branch) beat stall and flush; reaching PROG_END parks the unit until reset.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 17,
    parameter logic [ADDR_W-1:0] RESET_PC = 17'd0,
    parameter logic [ADDR_W-1:0] PROG_END = 17'd284
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ifid_instr;
    logic [ADDR_W-1:0] r_ifid_pc_plus4;
    logic              r_ifid_valid;
    logic              r_misalign_err;

    state_t            w_state_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic [31:0]       w_ifid_instr_next;
    logic [ADDR_W-1:0] w_ifid_pc_plus4_next;
    logic              w_ifid_valid_next;
    logic              w_misalign_err_next;
    logic [ADDR_W-1:0] w_redirect_target;
    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_redirect_target = bus.jump ? bus.jump_target : bus.branch_target;
    assign w_pc_plus4        = r_pc + PC_STEP;

    // Next-state and next-register selection in priority order.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_next         = r_state;
        w_pc_next            = r_pc;
        w_ifid_instr_next    = r_ifid_instr;
        w_ifid_pc_plus4_next = r_ifid_pc_plus4;
        w_ifid_valid_next    = r_ifid_valid;
        w_misalign_err_next  = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (bus.jump || bus.branch_taken) begin
                    // A redirect squashes whatever was being fetched.
                    w_pc_next           = w_redirect_target & ALIGN_MASK;
                    w_ifid_instr_next   = '0;
                    w_ifid_valid_next   = 1'b0;
                    w_misalign_err_next = |w_redirect_target[1:0];
                end else if (bus.stall) begin
                    // Hold PC and IF/ID as they are.
                end else if (bus.flush) begin
                    w_ifid_instr_next = '0;
                    w_ifid_valid_next = 1'b0;
                end else if (r_pc >= PROG_END) begin
                    w_state_next      = ST_HALTED;
                    w_ifid_instr_next = '0;
                    w_ifid_valid_next = 1'b0;
                end else begin
                    w_pc_next            = w_pc_plus4;
                    w_ifid_instr_next    = bus.imem_data;
                    w_ifid_pc_plus4_next = w_pc_plus4;
                    w_ifid_valid_next    = 1'b1;
                end
            end
            ST_HALTED: begin
                // Only reset leaves this state; keep IF/ID empty.
                w_ifid_instr_next = '0;
                w_ifid_valid_next = 1'b0;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            r_state         <= ST_RUN;
            r_pc            <= RESET_PC;
            r_ifid_instr    <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
            r_misalign_err  <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_ifid_instr    <= w_ifid_instr_next;
            r_ifid_pc_plus4 <= w_ifid_pc_plus4_next;
            r_ifid_valid    <= w_ifid_valid_next;
            r_misalign_err  <= w_misalign_err_next;
        end
    end

    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.halted        = (r_state == ST_HALTED);
    assign bus.misalign_err  = r_misalign_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized
// control traffic checked against a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam int          ADDR_W   = 17;
    localparam logic [16:0] RESET_PC = 17'd0;
    localparam logic [16:0] PROG_END = 17'd284;

    logic clk;
    logic reset;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .PROG_END(PROG_END)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Instruction memory: one random word per word address.
    logic [31:0] imem [0:32767];
    assign bus.imem_data = imem[bus.imem_addr[16:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the fetch stage.
    bit          m_halted;
    logic [16:0] m_pc;
    logic [31:0] m_instr;
    logic [16:0] m_pc4;
    bit          m_valid;
    bit          m_mis;

    // Advance the model with the current inputs, then clock the DUT and
    // settle just after the edge.
    task automatic tick();
        int tgt;
        m_mis = 1'b0;
        if (reset) begin
            m_halted = 0; m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (m_halted) begin
            m_instr = 0; m_valid = 0;
        end else if (bus.jump || bus.branch_taken) begin
            tgt     = bus.jump ? int'(bus.jump_target) : int'(bus.branch_target);
            m_pc    = 17'((tgt / 4) * 4);
            m_mis   = (tgt % 4) != 0;
            m_instr = 0; m_valid = 0;
        end else if (bus.stall) begin
            // nothing moves
        end else if (bus.flush) begin
            m_instr = 0; m_valid = 0;
        end else if (int'(m_pc) >= int'(PROG_END)) begin
            m_halted = 1; m_instr = 0; m_valid = 0;
        end else begin
            m_instr = imem[int'(m_pc) / 4];
            m_pc    = 17'((int'(m_pc) + 4) % (1 << ADDR_W));
            m_pc4   = m_pc;
            m_valid = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0;
        bus.branch_target = '0; bus.jump_target = '0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        tick(); tick();
        checks++; if (bus.imem_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", bus.imem_addr); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", bus.ifid_valid); end
        checks++; if (bus.ifid_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %0h expected 0", bus.ifid_instr); end
        checks++; if (bus.halted !== 1'b0 || bus.misalign_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b expected 00", bus.halted, bus.misalign_err); end
        reset = 0;
        tick(); tick(); tick();
        checks++; if (bus.ifid_pc_plus4 !== 17'd12) begin errors++; $display("FAIL seq_pc4 got %0d expected 12", bus.ifid_pc_plus4); end
        checks++; if (bus.ifid_instr !== imem[2]) begin errors++; $display("FAIL seq_instr got %0h expected %0h", bus.ifid_instr, imem[2]); end
        checks++; if (bus.imem_addr !== 17'd12) begin errors++; $display("FAIL seq_addr got %0d expected 12", bus.imem_addr); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %0b expected 1", bus.ifid_valid); end
    endtask

    task automatic test_stall();
        tick();
        bus.stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.imem_addr !== 17'd16) begin errors++; $display("FAIL stall_addr got %0d expected 16", bus.imem_addr); end
            checks++; if (bus.ifid_pc_plus4 !== 17'd16 || bus.ifid_instr !== imem[3] || bus.ifid_valid !== 1'b1) begin
                errors++; $display("FAIL stall_ifid got pc4=%0d instr=%0h expected pc4=16 instr=%0h", bus.ifid_pc_plus4, bus.ifid_instr, imem[3]);
            end
        end
        bus.stall = 0;
        tick();
        checks++; if (bus.imem_addr !== 17'd20 || bus.ifid_pc_plus4 !== 17'd20) begin
            errors++; $display("FAIL stall_release got addr=%0d pc4=%0d expected 20/20", bus.imem_addr, bus.ifid_pc_plus4);
        end
    endtask

    task automatic test_branch_over_stall();
        bus.branch_taken = 1; bus.branch_target = 17'd64; bus.stall = 1;
        tick();
        clear_inputs();
        checks++; if (bus.imem_addr !== 17'd64 || bus.ifid_valid !== 1'b0) begin
            errors++; $display("FAIL branch_redirect got addr=%0d valid=%0b expected 64/0", bus.imem_addr, bus.ifid_valid);
        end
        tick();
        checks++; if (bus.ifid_pc_plus4 !== 17'd68 || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== imem[16]) begin
            errors++; $display("FAIL branch_first got pc4=%0d valid=%0b instr=%0h expected 68/1/%0h", bus.ifid_pc_plus4, bus.ifid_valid, bus.ifid_instr, imem[16]);
        end
    endtask

    task automatic test_jump_misalign();
        bus.jump = 1; bus.jump_target = 17'd66; bus.branch_taken = 1; bus.branch_target = 17'd8;
        tick();
        clear_inputs();
        checks++; if (bus.imem_addr !== 17'd64 || bus.misalign_err !== 1'b1 || bus.ifid_valid !== 1'b0) begin
            errors++; $display("FAIL jump_misalign got addr=%0d mis=%0b valid=%0b expected 64/1/0", bus.imem_addr, bus.misalign_err, bus.ifid_valid);
        end
        tick();
        checks++; if (bus.misalign_err !== 1'b0 || bus.imem_addr !== 17'd68) begin
            errors++; $display("FAIL misalign_pulse got mis=%0b addr=%0d expected 0/68", bus.misalign_err, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        while (bus.imem_addr !== PROG_END && n < 200) begin tick(); n++; end
        checks++; if (bus.imem_addr !== PROG_END || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_reach got addr=%0d halted=%0b expected 284/0", bus.imem_addr, bus.halted);
        end
        tick();
        checks++; if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'd0 || bus.imem_addr !== PROG_END) begin
            errors++; $display("FAIL halt_enter got halted=%0b valid=%0b addr=%0d expected 1/0/284", bus.halted, bus.ifid_valid, bus.imem_addr);
        end
        bus.jump = 1; bus.jump_target = 17'd0;
        tick();
        clear_inputs();
        checks++; if (bus.imem_addr !== PROG_END || bus.halted !== 1'b1) begin
            errors++; $display("FAIL halt_ignore got addr=%0d halted=%0b expected 284/1", bus.imem_addr, bus.halted);
        end
        reset = 1; tick(); reset = 0;
        checks++; if (bus.imem_addr !== 17'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_reset got addr=%0d halted=%0b expected 0/0", bus.imem_addr, bus.halted);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        while (bus.imem_addr !== 17'd40 && n < 50) begin tick(); n++; end
        checks++; if (bus.imem_addr !== 17'd40) begin errors++; $display("FAIL midrun_reach got %0d expected 40", bus.imem_addr); end
        reset = 1; bus.jump = 1; bus.jump_target = 17'd101;
        tick();
        reset = 0; clear_inputs();
        checks++; if (bus.imem_addr !== RESET_PC || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'd0 ||
                      bus.ifid_pc_plus4 !== 17'd0 || bus.halted !== 1'b0 || bus.misalign_err !== 1'b0) begin
            errors++; $display("FAIL midrun_reset got addr=%0d valid=%0b instr=%0h pc4=%0d halted=%0b mis=%0b expected all 0",
                               bus.imem_addr, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_plus4, bus.halted, bus.misalign_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            bus.jump          = ($urandom_range(0, 29) == 0);
            bus.branch_taken  = ($urandom_range(0, 19) == 0);
            bus.stall         = ($urandom_range(0, 5) == 0);
            bus.flush         = ($urandom_range(0, 9) == 0);
            bus.jump_target   = 17'($urandom_range(0, 320));
            bus.branch_target = 17'($urandom_range(0, 320));
            tick();
            checks++;
            if (bus.imem_addr !== m_pc || bus.ifid_instr !== m_instr || bus.ifid_pc_plus4 !== m_pc4 ||
                bus.ifid_valid !== m_valid || bus.halted !== m_halted || bus.misalign_err !== m_mis) begin
                errors++;
                $display("FAIL random_cycle_%0d got addr=%0d instr=%0h pc4=%0d v=%0b h=%0b m=%0b expected addr=%0d instr=%0h pc4=%0d v=%0b h=%0b m=%0b",
                         i, bus.imem_addr, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.halted, bus.misalign_err,
                         m_pc, m_instr, m_pc4, m_valid, m_halted, m_mis);
            end
        end
        reset = 0; clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) imem[i] = $urandom;
        m_halted = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
        reset = 1;
        clear_inputs();
        test_reset();
        test_stall();
        test_branch_over_stall();
        test_jump_misalign();
        test_halt();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
